// File: rtl/heap_root.sv
// Root stage of the pipelined top-K min-heap: keeps the minimum, pushes replacements to level 1.
// Insert occupies 3 cycles (in_ready low 2), drops 1 cycle; in_ready low during PUSH/WAIT/INIT or on init_req.
module heap_root #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_LEVELS = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = {2'b01, {(DATA_WIDTH-2){1'b0}}},
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] root_data,
  output logic                  init_out,
  output logic                  dn_update,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic                  dn_branch,
  output logic [DATA_WIDTH-1:0] dn_data,
  input  logic                  up_we,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic [CNT_WIDTH-1:0]  accept_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {IDLE, PUSH, WAIT, INIT} state_t;

  localparam int IW = NUM_LEVELS + 2;
  // Counter runs from INIT_LAST down to 0 inclusive: (1<<NUM_LEVELS)+2 cycles in INIT.
  localparam logic [IW-1:0] INIT_LAST = IW'((1 << NUM_LEVELS) + 1);

  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic          take;

  function automatic logic cmp_lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [1:0] fa;
    logic [1:0] fb;
    fa = a[DATA_WIDTH-1:DATA_WIDTH-2];
    fb = b[DATA_WIDTH-1:DATA_WIDTH-2];
    cmp_lt = 1'b0;
    if (fa == 2'b01) begin
      cmp_lt = (fb == 2'b00) || (fb == 2'b11);
    end else if (fa == 2'b00) begin
      if (fb == 2'b11)      cmp_lt = 1'b1;
      else if (fb == 2'b00) cmp_lt = a[KEY_WIDTH-1:0] < b[KEY_WIDTH-1:0];
    end
  endfunction

  assign take = (in_data[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b00) && cmp_lt(root_data, in_data);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (init_req)              state_nxt = INIT;
        else if (in_valid && take) state_nxt = PUSH;
      end
      PUSH: state_nxt = WAIT;
      WAIT: state_nxt = IDLE;
      INIT: if (init_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !init_req;
    dn_addr   = '0;
    dn_branch = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      root_data  <= '0;
      dn_update  <= 1'b0;
      dn_data    <= '0;
      init_out   <= 1'b0;
      init_busy  <= 1'b0;
      init_cnt   <= '0;
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_req) begin
            init_out   <= 1'b1;
            init_busy  <= 1'b1;
            root_data  <= INIT_DATA;
            init_cnt   <= INIT_LAST;
            accept_cnt <= '0;
            drop_cnt   <= '0;
          end else if (in_valid) begin
            if (take) begin
              root_data <= in_data;
              dn_data   <= in_data;
              dn_update <= 1'b1;
              if (accept_cnt != '1) accept_cnt <= accept_cnt + CNT_WIDTH'(1);
            end else if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
          end
        end
        PUSH: dn_update <= 1'b0;
        // Level 1 writes back a smaller child only when it swapped at the root slot.
        WAIT: if (up_we && (up_addr == '0)) root_data <= up_data;
        INIT: begin
          init_out <= 1'b0;
          if (init_cnt == '0) init_busy <= 1'b0;
          else                init_cnt  <= init_cnt - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/heap_root.md
Name: heap_root

Overview:
- Level-0 (root) stage of the pipelined top-K min-heap.
- Holds the root element in a register and accepts new candidate items over a valid/ready handshake.
- A candidate strictly greater than the root replaces it; the replacement is then pushed to the level-1 sort node through that node's previous-level port.
- The root captures the sifted-up child that level 1 writes back, and sequences whole-heap initialisation.

Parameters:
- DATA_WIDTH, 32: element width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] are the flag: 00 normal, 01 min sentinel, 11 max sentinel.
- KEY_WIDTH, 16: key width; key is bits [KEY_WIDTH-1:0].
- ADDR_WIDTH, 5: heap node address width.
- NUM_LEVELS, 5: number of sort-node levels below the root.
- INIT_DATA, {2'b01, zeros}: min-sentinel value loaded at init.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- init_req  in  1  single-cycle request to initialise the heap
- init_busy  out  1  high while initialisation is running
- in_valid  in  1  candidate valid
- in_ready  out  1  candidate accepted when in_valid & in_ready
- in_data  in  DATA_WIDTH  candidate element
- root_data  out  DATA_WIDTH  current root (minimum of the kept top-K)
- init_out  out  1  init strobe to all sort nodes
- dn_update  out  1  to level-1 pl_update_in
- dn_addr  out  ADDR_WIDTH  to level-1 pl_addr_in; constant 0
- dn_branch  out  1  to level-1 pl_branch_in; constant 0
- dn_data  out  DATA_WIDTH  to level-1 pl_in
- up_we  in  1  level-1 um_we
- up_addr  in  ADDR_WIDTH  level-1 um_addr
- up_data  in  DATA_WIDTH  level-1 um_out
- accept_cnt  out  CNT_WIDTH  candidates inserted
- drop_cnt  out  CNT_WIDTH  candidates rejected

Behaviour:
- Reset (async, rstn low) sets every output to 0 and returns the FSM to IDLE:
  - state=IDLE, root_data=0, dn_update=0, dn_data=0, init_out=0, init_busy=0, counters=0.
  - in_ready reads 1 after reset because it is combinational from IDLE.
- Compare function cmp_lt(a,b):
  - 01 (min sentinel) is less than 00 and 11.
  - 11 (max sentinel) is never less.
  - 00 vs 00 is an unsigned key compare.
  - Flag 10 is never less and is never greater.
- Every state sets dn_addr=0 and dn_branch=0.
- in_ready = (state==IDLE) & ~init_req. This is combinational.
- FSM states: IDLE, PUSH, WAIT, INIT.
- IDLE:
  - If init_req: go to INIT. Register init_out<=1, init_busy<=1, root_data<=INIT_DATA, and clear both counters. If in_valid is also high, init wins and the candidate is not accepted.
  - Else, on a handshake where flag==00 and cmp_lt(root_data,in_data): root_data<=in_data, dn_data<=in_data, dn_update<=1, accept_cnt++. Go to PUSH.
  - Else, on a handshake: drop_cnt++ and stay in IDLE. This covers equal keys, smaller keys and non-00 flags.
- PUSH (1 cycle): dn_update is visible to level 1 for exactly this cycle. dn_update<=0. Go to WAIT.
- WAIT (1 cycle):
  - If up_we & up_addr==0: root_data<=up_data (level 1 swapped a smaller child up).
  - Otherwise root_data is unchanged.
  - Go to IDLE.
  - up_we outside WAIT is ignored.
- Throughput: one insertion per 3 cycles. Drops take 1 cycle each, back-to-back.
- INIT:
  - init_out is high only in the first INIT cycle.
  - A down-counter runs for (1<<NUM_LEVELS)+2 cycles. When it expires: init_busy<=0, go to IDLE.
  - init_req is ignored outside IDLE. The requester retries.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-PUSH, mid-WAIT or mid-INIT aborts immediately to the reset values. Heap RAM contents are undefined until the next init.

Test Plan:
- Reset, then init_req pulse with NUM_LEVELS=5 -> init_out high 1 cycle, init_busy high 34 cycles, root_data=32'h4000_0000, in_ready=0 throughout.
- After init, in_data=32'h0000_0010 valid -> accepted, root_data=32'h0000_0010, dn_update one cycle later with dn_data=32'h0000_0010, dn_addr=0, accept_cnt=1, in_ready low 2 cycles.
- Root=0x0010, model level 1 returning up_we=1, up_addr=0, up_data=32'h4000_0000 in WAIT -> root_data=32'h4000_0000. Same stimulus but with up_we pulsed in IDLE -> root unchanged.
- Root=32'h0000_0020; feed keys 0x0020, 0x0005, then flag 11 item, back-to-back -> all dropped in 3 consecutive cycles, drop_cnt=3, no dn_update.
- init_req and in_valid asserted in the same IDLE cycle -> in_ready=0, INIT entered, candidate not counted. init_req pulsed during PUSH -> ignored.
- CNT_WIDTH=2; perform 5 inserts of increasing keys 1..5 -> accept_cnt saturates at 3. Assert rstn low during WAIT -> all outputs 0 asynchronously, state IDLE.
